ifetch_buffer: RTL

Instruction fetch buffer between the program-counter register and the decode stage. It owns the sequential fetch pointer, issues word reads to instruction memory over a req/ack handshake, and queues returned instructions with their PCs in a small FIFO. Decode consumes instructions under a valid/ready handshake. Branch/jump redirects flush the queue and discard any in-flight read. A halt request stops new fetches while queued instructions drain.

---
 rtl/ifetch_buffer_pkg.sv | 19 +
 rtl/ifetch_buffer_inst_fifo.sv | 59 +++++
 rtl/ifetch_buffer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ifetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer: fetch FSM states and the
// (instruction, pc) entry carried through the queue.
package ifetch_buffer_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IFB_FETCH = 2'd0,
    IFB_WAIT  = 2'd1,
    IFB_DRAIN = 2'd2,
    IFB_HALT  = 2'd3
  } ifb_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] pc;
  } fifo_entry_t;

endpackage

// File: rtl/ifetch_buffer_inst_fifo.sv
// DEPTH-entry queue of (instruction, pc) pairs with flush; head is forced to
// zero while empty so decode never sees stale words.
module inst_fifo
  import ifetch_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wdata,
  output fifo_entry_t head,
  output logic        head_valid,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != FULL) || do_pop);
  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;

  always_ff @(negedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(negedge clk) begin
    if (clr || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: owns the sequential fetch pointer, issues word reads
// over req/ack and queues returned instructions with their PCs for decode.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] fetched_count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  ifb_state_t  state;
  ifb_state_t  state_n;
  logic [31:0] ptr;
  logic [31:0] ptr_n;
  logic [31:0] addr_n;
  logic        req_n;
  logic        halted;
  logic        halt_eff;
  logic        complete;
  logic        issue;
  logic        can_issue;
  logic        fifo_push;
  logic        fifo_pop;
  logic [AW:0] fifo_count;
  fifo_entry_t fifo_head;

  assign complete  = imem_req && imem_ack;
  assign halt_eff  = halted || halt;
  assign fifo_push = complete && (state == IFB_WAIT) && !redirect_valid;
  assign fifo_pop  = inst_valid && inst_ready && !redirect_valid;
  // Pre-pop count plus the word landing now: a full queue being drained still
  // blocks issue for this edge, so the queue can never overflow.
  assign can_issue = (fifo_count + (AW+1)'(fifo_push)) < DEPTH_C;

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .clr        (clr),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .wdata      ('{inst: imem_rdata, pc: imem_addr}),
    .head       (fifo_head),
    .head_valid (inst_valid),
    .count      (fifo_count)
  );

  assign inst    = fifo_head.inst;
  assign inst_pc = fifo_head.pc;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    addr_n  = imem_addr;
    req_n   = imem_req;
    issue   = 1'b0;
    if (redirect_valid) begin
      ptr_n = redirect_pc;
    end else if (fifo_push) begin
      ptr_n = ptr + 32'd1;
    end
    unique case (state)
      IFB_FETCH: begin
        if (halt_eff) begin
          state_n = IFB_HALT;
        end else begin
          issue = redirect_valid || can_issue;
        end
      end
      IFB_WAIT: begin
        if (complete) begin
          state_n = halt_eff ? IFB_HALT : IFB_FETCH;
          req_n   = 1'b0;
          issue   = !halt_eff && (redirect_valid || can_issue);
        end else if (redirect_valid) begin
          state_n = IFB_DRAIN;
        end
      end
      // The abandoned read must still finish on its old address before the
      // redirect target can be requested.
      IFB_DRAIN: begin
        if (complete) begin
          state_n = halt_eff ? IFB_HALT : IFB_FETCH;
          req_n   = 1'b0;
        end
      end
      IFB_HALT: begin
        state_n = IFB_HALT;
      end
    endcase
    if (issue) begin
      state_n = IFB_WAIT;
      req_n   = 1'b1;
      addr_n  = ptr_n;
    end
  end

  // State moves on the falling edge so it lines up with the PC register.
  always_ff @(negedge clk) begin
    if (clr) begin
      state         <= IFB_FETCH;
      ptr           <= '0;
      imem_addr     <= '0;
      imem_req      <= 1'b0;
      halted        <= 1'b0;
      fetched_count <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      imem_addr <= addr_n;
      imem_req  <= req_n;
      halted    <= halt_eff;
      if (fifo_pop) begin
        fetched_count <= fetched_count + 32'd1;
      end
    end
  end

endmodule
